// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the shared-shifter arbiter:
//   shift_op_t  - 2-bit shift operation code (SLL/SRL/SRA/reserved)
//   out_state_t - output stage occupancy (EMPTY/FULL)
//   SHIFT_N     - default datapath width
//   SHIFT_SHW   - shift-amount width for SHIFT_N
// ----------------------------------------------------------------------------
package shift_pkg;

  localparam int SHIFT_N   = 32;
  localparam int SHIFT_SHW = $clog2(SHIFT_N);

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage : shift_pkg

// File: rtl/shift_unit.sv
// ----------------------------------------------------------------------------
// shift_unit
// Purely combinational N-bit shifter with an op select.
// Ports:
//   in_i    [N-1:0]          operand
//   shamt_i [$clog2(N)-1:0]  unsigned shift amount (0..N-1)
//   op_i    shift_op_t       SLL / SRL / SRA / reserved (pass-through)
//   out_o   [N-1:0]          shifted result
// ----------------------------------------------------------------------------
module shift_unit
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic [N-1:0]         in_i,
  input  logic [$clog2(N)-1:0] shamt_i,
  input  shift_op_t            op_i,
  output logic [N-1:0]         out_o
);

  logic [N-1:0] sll_s;
  logic [N-1:0] srl_s;
  logic [N-1:0] sra_s;

  // Three independent shifters; the op mux below picks one.
  always_comb begin
    sll_s = in_i << shamt_i;
    srl_s = in_i >> shamt_i;
    // Arithmetic shift needs a signed operand so the vacated bits copy in_i[N-1].
    sra_s = N'($signed(in_i) >>> shamt_i);
  end

  // Op select; the reserved code passes the operand through unchanged.
  always_comb begin
    out_o = in_i;
    case (op_i)
      SHIFT_SLL:  out_o = sll_s;
      SHIFT_SRL:  out_o = srl_s;
      SHIFT_SRA:  out_o = sra_s;
      SHIFT_RSVD: out_o = in_i;
      default:    out_o = in_i;
    endcase
  end

endmodule : shift_unit

// File: rtl/shift_arbiter.sv
// ----------------------------------------------------------------------------
// shift_arbiter
// Shares one combinational shift_unit between two requesters using
// round-robin arbitration, with a one-entry registered output stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (ready = accepted this cycle)
//   req{0,1}_in/_shamt/_op    request payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_out                   registered shift result
//   rsp_id                    requester that issued rsp_out
// ----------------------------------------------------------------------------
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N-1:0]         req0_in,
  input  logic [$clog2(N)-1:0] req0_shamt,
  input  logic [1:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N-1:0]         req1_in,
  input  logic [$clog2(N)-1:0] req1_shamt,
  input  logic [1:0]           req1_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_out,
  output logic                 rsp_id
);

  out_state_t           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [N-1:0]         rsp_out_q, rsp_out_d;
  logic                 rsp_id_q, rsp_id_d;

  logic                 grant_s;
  logic                 can_accept_s;
  logic                 accept_s;
  logic [N-1:0]         sel_in_s;
  logic [$clog2(N)-1:0] sel_shamt_s;
  logic [1:0]           sel_op_s;
  logic [N-1:0]         shift_res_s;

  // Round-robin grant: a tie goes to the requester that did not win last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Handshake: the stage can take a new op when empty or being drained now.
  // Reset gates the readies so nothing is accepted during a reset cycle.
  always_comb begin
    can_accept_s = (state_q == OUT_EMPTY) | rsp_ready;
    req0_ready   = ~rst & can_accept_s & ~grant_s & req0_valid;
    req1_ready   = ~rst & can_accept_s &  grant_s & req1_valid;
    accept_s     = req0_ready | req1_ready;
  end

  // Payload mux feeding the single shared shifter.
  always_comb begin
    if (grant_s) begin
      sel_in_s    = req1_in;
      sel_shamt_s = req1_shamt;
      sel_op_s    = req1_op;
    end else begin
      sel_in_s    = req0_in;
      sel_shamt_s = req0_shamt;
      sel_op_s    = req0_op;
    end
  end

  shift_unit #(.N(N)) u_shift (
    .in_i    (sel_in_s),
    .shamt_i (sel_shamt_s),
    .op_i    (shift_op_t'(sel_op_s)),
    .out_o   (shift_res_s)
  );

  // Output stage next state; a drain and a fill in the same cycle stay FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: begin
        if (accept_s) state_d = OUT_FULL;
        else          state_d = OUT_EMPTY;
      end
      OUT_FULL: begin
        if (accept_s)       state_d = OUT_FULL;
        else if (rsp_ready) state_d = OUT_EMPTY;
        else                state_d = OUT_FULL;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Result/grant capture; everything holds unless an op is accepted.
  always_comb begin
    rsp_out_d    = rsp_out_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      rsp_out_d    = shift_res_s;
      rsp_id_d     = grant_s;
      last_grant_d = grant_s;
    end else begin
      rsp_out_d    = rsp_out_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OUT_EMPTY;
      last_grant_q <= 1'b1;
      rsp_out_q    <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_out_q    <= rsp_out_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == OUT_FULL);
  assign rsp_out   = rsp_out_q;
  assign rsp_id    = rsp_id_q;

endmodule : shift_arbiter
